// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with persistent ownership.
// Grant is one-hot plus binary index (8-to-3 encoder encoding), all registered.
// Optional hold timeout enabled by defining RR_ARB_TIMEOUT_EN; without it the
// owner keeps the grant for as long as it requests and MAX_HOLD is ignored.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Catch an out-of-range hold limit at elaboration time.
  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("rr_arbiter_8: MAX_HOLD must be in 2..256");
  end

  state_t     state_q, state_d;
  logic [2:0] last_q, last_d;
  logic [7:0] gnt_d;
  logic [2:0] gnt_idx_d;
  logic       gnt_valid_d;

  logic [2:0] win_all;
  logic       win_all_ok;
  logic       grant_en;
  logic [2:0] grant_sel;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned          HOLD_W   = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0]    HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        win_oth;
  logic              win_oth_ok;

  // Winner among everyone except the current owner (timeout handoff).
  always_comb begin
    win_oth    = '0;
    win_oth_ok = 1'b0;
    for (int k = 6; k >= 0; k--) begin
      if (req[last_q + 3'(k + 1)]) begin
        win_oth    = last_q + 3'(k + 1);
        win_oth_ok = 1'b1;
      end
    end
  end
`endif

  // Rotating priority search from last_q+1; last_q itself is tried last.
  always_comb begin
    win_all    = '0;
    win_all_ok = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (req[last_q + 3'(k + 1)]) begin
        win_all    = last_q + 3'(k + 1);
        win_all_ok = 1'b1;
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt;
    gnt_idx_d   = gnt_idx;
    gnt_valid_d = gnt_valid;
    grant_en    = 1'b0;
    grant_sel   = '0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d      = hold_q;
`endif

    case (state_q)
      IDLE: begin
        if (win_all_ok) begin
          grant_en  = 1'b1;
          grant_sel = win_all;
        end
      end
      GRANT: begin
        if (req[last_q]) begin
`ifdef RR_ARB_TIMEOUT_EN
          if (hold_q == HOLD_MAX && win_oth_ok) begin
            grant_en  = 1'b1;
            grant_sel = win_oth;
          end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
          end
`endif
        end else if (win_all_ok) begin
          grant_en  = 1'b1;
          grant_sel = win_all;
        end else begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new grant (from idle, release or timeout) loads the same fields.
    if (grant_en) begin
      state_d     = GRANT;
      last_d      = grant_sel;
      gnt_d       = 8'b1 << grant_sel;
      gnt_idx_d   = grant_sel;
      gnt_valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
      hold_d      = '0;
`endif
    end
  end

  // State and registered outputs; reset points priority at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 3'd7;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt       <= gnt_d;
      gnt_idx   <= gnt_idx_d;
      gnt_valid <= gnt_valid_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios then randomized traffic, all
// compared against a behavioural ownership model (honours RR_ARB_TIMEOUT_EN).
module tb_rr_arbiter_8;

  localparam int unsigned MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: current owner (-1 when idle), last granted, cycles held.
  int m_owner = -1;
  int m_last  = 7;
  int m_hold  = 0;

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  // First requester in round-robin order after 'last'; optionally skip 'last'.
  function automatic int pick(int last, logic [7:0] r, bit skip_self);
    int order[$];
    for (int k = 1; k <= 8; k++) order.push_back((last + k) % 8);
    if (skip_self) void'(order.pop_back());
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_edge(input bit r_rst, input logic [7:0] r);
    int w;
    if (r_rst) begin
      m_owner = -1; m_last = 7; m_hold = 0;
      return;
    end
    if (m_owner < 0 || !r[m_owner]) begin
      w = pick(m_last, r, 1'b0);
      if (w < 0) m_owner = -1;
      else begin m_owner = w; m_last = w; m_hold = 0; end
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      w = (m_hold == MAX_HOLD - 1) ? pick(m_last, r, 1'b1) : -1;
      if (w >= 0) begin m_owner = w; m_last = w; m_hold = 0; end
      else if (m_hold < MAX_HOLD - 1) m_hold++;
`endif
    end
  endtask

  function automatic logic [7:0] exp_gnt();
    return (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] eg;
    eg = exp_gnt();
    check({tag, "/gnt"}, gnt, eg);
    check({tag, "/gnt_idx"}, 8'(gnt_idx), (m_owner < 0) ? 8'd0 : 8'(m_owner));
    check({tag, "/gnt_valid"}, 8'(gnt_valid), (m_owner < 0) ? 8'd0 : 8'd1);
  endtask

  // Drive one cycle: inputs set after negedge, outputs checked at next negedge.
  task automatic step(input bit r_rst, input logic [7:0] r, input string tag);
    rst = r_rst;
    req = r;
    #1;
    check({tag, "/no_comb_path"}, gnt, exp_gnt());
    @(posedge clk);
    model_edge(r_rst, r);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] r;
    bit         rr;
    rst = 1'b1;
    req = 8'h00;
    @(negedge clk);

    // Reset held with all requests pending.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hFF, "reset");
      check("reset_gnt_zero", gnt, 8'h00);
    end
    step(1'b0, 8'hFF, "first_grant");
    check("first_grant_lit", gnt, 8'h01);

    // Single requester from idle.
    step(1'b1, 8'h00, "single_rst");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'b0000_0100, "single_hold");
      check("single_idx_lit", 8'(gnt_idx), 8'd2);
    end
    step(1'b0, 8'h00, "single_release");
    check("single_release_lit", 8'(gnt_valid), 8'd0);

    // Full rotation: each owner drops its bit for one cycle.
    step(1'b1, 8'h00, "rot_rst");
    step(1'b0, 8'hFF, "rot_start");
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'hFF & ~(8'h01 << m_owner), "rotation");
      check("rotation_idx_lit", 8'(gnt_idx), 8'(i % 8));
    end

    // Wrap priority from owner 5.
    step(1'b1, 8'h00, "wrap_rst");
    step(1'b0, 8'b0010_0000, "wrap_own5");
    step(1'b0, 8'b0010_1001, "wrap_hold5");
    step(1'b0, 8'b0000_1001, "wrap_release");
    check("wrap_gnt_lit", gnt, 8'b0000_0001);

    // Hold timeout with two constant requesters.
    step(1'b1, 8'h00, "to_rst");
    step(1'b0, 8'b0000_0011, "to_grant0");
    for (int i = 0; i < 16; i++) step(1'b0, 8'b0000_0011, "to_hold");
`ifdef RR_ARB_TIMEOUT_EN
    check("timeout_to1_lit", 8'(gnt_idx), 8'd1);
`else
    check("timeout_off_lit", 8'(gnt_idx), 8'd0);
`endif
    for (int i = 0; i < 16; i++) step(1'b0, 8'b0000_0011, "to_hold2");
    check("timeout_back0_lit", 8'(gnt_idx), 8'd0);
    for (int i = 0; i < 90; i++) step(1'b0, 8'b0000_0011, "to_long");

    // Reset in the middle of a grant.
    step(1'b1, 8'h00, "mid_rst0");
    step(1'b0, 8'b0000_1000, "mid_own3");
    step(1'b1, 8'hFF, "mid_rst");
    check("mid_rst_lit", gnt, 8'h00);
    step(1'b0, 8'hFF, "mid_after");
    check("mid_after_lit", 8'(gnt_idx), 8'd0);

    // Randomized traffic with varied density and occasional reset.
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r = 8'($urandom) & 8'($urandom) & 8'($urandom);
        2: r = r;
        default: r = (m_owner >= 0) ? (r & ~(8'h01 << m_owner)) | 8'($urandom_range(0, 255) & 8'h81) : 8'hFF;
      endcase
      rr = ($urandom_range(0, 49) == 0);
      step(rr, r, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one resource among eight requesters. It produces a one-hot grant and its 3-bit encoded index. The index is the same encoding the team's 8-to-3 encoder produces, so the grant can drive a downstream mux select directly. The arbiter sits between the requesting masters and the shared datapath. Ownership persists until the owner drops its request; an optional hold-timeout forces rotation.

## Interface
- `MAX_HOLD`, default 16: cycles an owner may keep the grant while others wait. Used only with the timeout feature; legal range 2..256.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 8: per-requester request; bit i belongs to requester i.
- `gnt` output 8: one-hot grant, registered; all-zero when idle.
- `gnt_idx` output 3: binary index of the set `gnt` bit; 0 when idle.
- `gnt_valid` output 1: high when any `gnt` bit is set.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - 3-bit `last_idx` pointer: index of the most recent grant.
  - Hold counter, $clog2(MAX_HOLD) bits.
- Priority search: candidates in order `last_idx`+1, +2, … +8, modulo 8. The first set `req` bit wins. `last_idx`+8 (the previous owner itself) is considered last.
- IDLE:
  - If `req` ≠ 0: grant the winner, set `last_idx` = winner, clear the hold counter, go to GRANT.
  - Otherwise remain in IDLE.
- GRANT with `req[last_idx]` = 1: keep the grant. The hold counter increments and saturates at MAX_HOLD-1.
- GRANT with `req[last_idx]` = 0 (release):
  - If any other `req` bit is set: grant the next winner at the same edge (direct handoff, no idle bubble), set `last_idx` = winner, clear the counter.
  - Otherwise clear the grant and go to IDLE. `last_idx` keeps its value, so rotation continues.
- Invariants:
  - `gnt` always has at most one bit set.
  - `gnt_idx` always equals the encoding of `gnt`.
  - `gnt_valid` = |`gnt`.
- The granted requester must not be re-granted while any other requester is waiting after it releases.

## Timing
- Reset: the edge with `rst`=1 forces:
  - `gnt`=8'h00, `gnt_idx`=3'd0, `gnt_valid`=0;
  - FSM to IDLE, `last_idx`=3'd7 (first priority goes to requester 0), hold counter=0.
  - `rst` overrides all other inputs.
  - Reset mid-grant drops the grant at that edge.
- Grant latency: `req` sampled at edge N; `gnt` valid after edge N, i.e. one cycle.
- Release latency: owner deasserts `req` before edge N; the grant clears or hands off after edge N.
- A requester that reasserts in the same cycle it is released competes normally. It loses to any other pending requester.
- Simultaneous release and new requests: evaluated at the same edge by the normal priority search.
- Wrap-around: search from `last_idx`=7 begins at 0; from 5 the order is 6, 7, 0, 1, …
- All outputs are registered; there is no combinational path from `req` to `gnt`.

## Configuration
- Macro: `RR_ARB_TIMEOUT_EN`.
- Defined:
  - In GRANT, when the hold counter = MAX_HOLD-1 and any other `req` bit is set, the grant is revoked at the next edge. It is handed to the next winner, excluding the current owner, even though the owner still requests.
  - The counter clears on every new grant.
  - If no other requester is pending, the owner keeps the grant and the counter stays saturated.
- Undefined:
  - The counter logic is not compiled.
  - The owner keeps the grant indefinitely while `req[last_idx]`=1.
  - `MAX_HOLD` is ignored.

## Test plan
- Reset: hold `rst`=1 with `req`=8'hFF for 3 cycles. Required: `gnt`=8'h00, `gnt_idx`=0, `gnt_valid`=0 throughout. Release `rst`; the next edge gives `gnt`=8'h01, `gnt_idx`=0.
- Single requester: `req`=8'b00000100. One cycle later: `gnt`=8'b00000100, `gnt_idx`=2, `gnt_valid`=1, held while `req` stays high. Set `req`=0; the next edge gives `gnt`=0, `gnt_valid`=0.
- Full rotation: `req`=8'hFF, with each owner dropping its bit for one cycle after being granted. Required grant sequence: `gnt_idx` 0,1,2,3,4,5,6,7,0 with no idle cycles between handoffs.
- Wrap priority: owner 5, `req`=8'b00101001, then requester 5 drops so `req`=8'b00001001. Required: next `gnt`=8'b00000001, `gnt_idx`=0 (search order 6, 7, 0).
- Timeout: `req`=8'b00000011 constant, MAX_HOLD=16, owner 0.
  - With `RR_ARB_TIMEOUT_EN`: the grant moves to idx 1 after 16 cycles of ownership, then back to idx 0 after 16 more.
  - Without the macro: `gnt_idx` stays 0 for 100+ cycles.
- Reset mid-grant: owner 3, assert `rst` for 1 cycle with `req`=8'hFF. Required: outputs zero after that edge; the next grant is idx 0.
